// File: rtl/mult_pkg.sv
// Shared types and helpers for the digit-serial multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // Widest operand the magnitude helper can handle.
    localparam int MAXW = 128;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Magnitude of a width-bit value when signed_mode is set and it is negative; raw otherwise.
    function automatic logic [MAXW-1:0] abs_if_signed(input logic [MAXW-1:0] value,
                                                      input int width,
                                                      input logic signed_mode);
        logic [MAXW-1:0] mask;
        mask = (MAXW'(1) << width) - MAXW'(1);
        if (signed_mode && value[width-1])
            return (~value + MAXW'(1)) & mask;
        return value & mask;
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// One digit-by-digit partial product, shifted into full product alignment.
module mult_digit_pp
    import mult_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int A_DIGIT = 8,
    parameter int B_DIGIT = 16,
    parameter int IW      = 2,
    parameter int JW      = 1
) (
    input  logic [A_WIDTH-1:0]         a_op,
    input  logic [B_WIDTH-1:0]         b_op,
    input  logic [IW-1:0]              i_idx,
    input  logic [JW-1:0]              j_idx,
    output logic [A_WIDTH+B_WIDTH-1:0] pp
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int DW = A_DIGIT + B_DIGIT;

    logic [A_DIGIT-1:0] a_dig;
    logic [B_DIGIT-1:0] b_dig;
    logic [DW-1:0]      dp;
    int                 sh;

    always_comb begin
        a_dig = a_op[int'(i_idx) * A_DIGIT +: A_DIGIT];
        b_dig = b_op[int'(j_idx) * B_DIGIT +: B_DIGIT];
        dp    = DW'(a_dig) * DW'(b_dig);
        sh    = int'(i_idx) * A_DIGIT + int'(j_idx) * B_DIGIT;
        pp    = PW'(dp) << sh;
    end

endmodule

// File: rtl/mult_seq_param.sv
// Digit-serial sign/magnitude multiplier: one partial product per clock, sign fixed up at the end.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int A_DIGIT = 8,
    parameter int B_DIGIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int NA = A_WIDTH / A_DIGIT;
    localparam int NB = B_WIDTH / B_DIGIT;
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int IW = cnt_w(NA);
    localparam int JW = cnt_w(NB);

    if ((A_WIDTH % A_DIGIT) != 0) begin : g_bad_a
        $fatal(1, "A_WIDTH must be a multiple of A_DIGIT");
    end
    if ((B_WIDTH % B_DIGIT) != 0) begin : g_bad_b
        $fatal(1, "B_WIDTH must be a multiple of B_DIGIT");
    end

    state_t             state;
    logic [A_WIDTH-1:0] a_lat;
    logic [B_WIDTH-1:0] b_lat;
    logic               neg;
    logic [IW-1:0]      i_cnt;
    logic [JW-1:0]      j_cnt;
    logic [PW-1:0]      pp;

    mult_digit_pp #(
        .A_WIDTH(A_WIDTH),
        .B_WIDTH(B_WIDTH),
        .A_DIGIT(A_DIGIT),
        .B_DIGIT(B_DIGIT),
        .IW     (IW),
        .JW     (JW)
    ) u_pp (
        .a_op (a_lat),
        .b_op (b_lat),
        .i_idx(i_cnt),
        .j_idx(j_cnt),
        .pp   (pp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            neg     <= 1'b0;
            i_cnt   <= '0;
            j_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat   <= A_WIDTH'(abs_if_signed(MAXW'(a), A_WIDTH, signed_mode));
                        b_lat   <= B_WIDTH'(abs_if_signed(MAXW'(b), B_WIDTH, signed_mode));
                        neg     <= signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                        product <= '0;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    product <= product + pp;
                    // a digits sweep fastest; the last b digit's last a digit ends the run
                    if (i_cnt == IW'(NA - 1)) begin
                        i_cnt <= '0;
                        if (j_cnt == JW'(NB - 1)) begin
                            j_cnt <= '0;
                            state <= FIN;
                        end else begin
                            j_cnt <= j_cnt + JW'(1);
                        end
                    end else begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                FIN: begin
                    if (neg)
                        product <= -product;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param at default and alternate digit parameters.
module tb_mult_seq_param;

    logic        clk;
    logic        reset;
    logic        start1, sm1, busy1, done1;
    logic [31:0] a1, b1;
    logic [63:0] product1;
    logic        start2, sm2, busy2, done2;
    logic [15:0] a2;
    logic [7:0]  b2;
    logic [23:0] product2;

    int checks = 0;
    int errors = 0;

    logic [63:0] q1[$];
    logic [23:0] q2[$];

    mult_seq_param dut (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .product(product1)
    );

    mult_seq_param #(.A_WIDTH(16), .B_WIDTH(8), .A_DIGIT(4), .B_DIGIT(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor for the default instance: pop expected product on each done pulse.
    initial begin
        int bc;
        logic [63:0] e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bc = 0;
            end else begin
                if (busy1) bc++;
                if (done1) begin
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL done1_unexpected product=%h", product1);
                    end else begin
                        e = q1.pop_front();
                        if (product1 !== e) begin
                            errors++;
                            $display("FAIL product1 got=%h exp=%h", product1, e);
                        end
                    end
                    checks++;
                    if (bc != 9 || busy1 !== 1'b0) begin
                        errors++;
                        $display("FAIL busy1_cycles got=%0d busy=%b exp=9 busy=0", bc, busy1);
                    end
                    bc = 0;
                end
            end
        end
    end

    initial begin
        int bc;
        logic [23:0] e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bc = 0;
            end else begin
                if (busy2) bc++;
                if (done2) begin
                    checks++;
                    if (q2.size() == 0) begin
                        errors++;
                        $display("FAIL done2_unexpected product=%h", product2);
                    end else begin
                        e = q2.pop_front();
                        if (product2 !== e) begin
                            errors++;
                            $display("FAIL product2 got=%h exp=%h", product2, e);
                        end
                    end
                    checks++;
                    if (bc != 9 || busy2 !== 1'b0) begin
                        errors++;
                        $display("FAIL busy2_cycles got=%0d busy=%b exp=9 busy=0", bc, busy2);
                    end
                    bc = 0;
                end
            end
        end
    end

    task automatic op1(input logic [31:0] ta, input logic [31:0] tb, input logic sm,
                       input logic [63:0] e, input bit push);
        a1 = ta; b1 = tb; sm1 = sm; start1 = 1'b1;
        if (push) q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic op2(input logic [15:0] ta, input logic [7:0] tb, input logic sm,
                       input logic [23:0] e);
        a2 = ta; b2 = tb; sm2 = sm; start2 = 1'b1;
        q2.push_back(e);
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit);
        bit got;
        got = 0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            if ((which == 1 && done1) || (which == 2 && done2)) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d got=no_done exp=done within %0d cycles", which, limit);
        end
    endtask

    initial begin
        reset = 1'b0;
        start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || product1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h exp=0/0/0", busy1, done1, product1);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        op1(32'd23, 32'd45, 1'b0, 64'd1035, 1'b1);
        wait_done(1, 30);
        op1(32'hFFFF_FFE9, 32'd45, 1'b1, 64'hFFFF_FFFF_FFFF_FBF5, 1'b1);
        wait_done(1, 30);
        op1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_done(1, 30);
        op1(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        wait_done(1, 30);
        op1(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
        wait_done(1, 30);
        op1(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42, 1'b1);
        wait_done(1, 30);

        // start stays high through busy while operands change underneath
        a1 = 32'd23; b1 = 32'd45; sm1 = 1'b0; start1 = 1'b1;
        q1.push_back(64'd1035);
        @(posedge clk); #1;
        a1 = 32'd100; b1 = 32'd200; sm1 = 1'b1;
        wait_done(1, 30);
        q1.push_back(64'd20000);
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1, 30);

        // asynchronous reset in the 4th RUN cycle abandons the operation
        @(posedge clk); #1;
        op1(32'd23, 32'd45, 1'b0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || product1 !== 64'd0) begin
            errors++;
            $display("FAIL async_reset got=%b/%b/%h exp=0/0/0", busy1, done1, product1);
        end
        @(negedge clk); #1;
        reset = 1'b1;
        op1(32'd7, 32'd6, 1'b0, 64'd42, 1'b1);
        wait_done(1, 30);

        op2(16'hFFFF, 8'hFF, 1'b0, 24'hFEFF01);
        wait_done(2, 30);
        op2(16'hFFFF, 8'hFF, 1'b1, 24'h000001);
        wait_done(2, 30);
        op2(16'h8000, 8'h80, 1'b1, 24'h400000);
        wait_done(2, 30);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", q1.size(), q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
